// File: rtl/divider_unsigned_iter.sv
// Multi-cycle unsigned integer divider (restoring shift-subtract).
// Retires BITS_PER_CYCLE quotient bits per clock, MSB first. It produces the
// quotient and remainder for DIVU/REMU. Signed DIV/REM is handled by sign
// wrapping outside this block.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   i_valid/i_ready   operand handshake (i_ready high only while idle)
//   i_dividend        unsigned dividend
//   i_divisor         unsigned divisor
//   o_valid/o_ready   result handshake (result held until taken)
//   o_quotient        quotient (all ones on divide by zero)
//   o_remainder       remainder (dividend on divide by zero)
//   o_div_by_zero     divisor of the presented result was zero
module divider_unsigned_iter #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  // After STEPS cycles this register holds the quotient.
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_out_q, dbz_out_d;

  // Datapath for one clock's worth of chained steps.
  logic [WIDTH:0]   r_v;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] dq_v;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_dq;

  always_comb begin
    r_v     = rem_q;
    dq_v    = dq_q;
    shifted = '0;
    sum     = '0;
    for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
      shifted = {r_v[WIDTH-1:0], dq_v[WIDTH-1]};
      // The adder computes shifted + ~divisor + 1. Its carry-out is set
      // exactly when no borrow occurs, i.e. shifted >= divisor.
      sum = {1'b0, shifted} + {1'b0, ~{1'b0, dvs_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
      if (sum[WIDTH+1]) begin
        r_v  = sum[WIDTH:0];
        dq_v = {dq_v[WIDTH-2:0], 1'b1};
      end else begin
        r_v  = shifted;
        dq_v = {dq_v[WIDTH-2:0], 1'b0};
      end
    end
    step_rem = r_v;
    step_dq  = dq_v;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dq_d      = dq_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_out_d = dbz_out_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          dq_d    = i_dividend;
          dvs_d   = i_divisor;
          dbz_d   = (i_divisor == '0);
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        rem_d = step_rem;
        dq_d  = step_dq;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) begin
          quo_out_d = step_dq;
          rem_out_d = step_rem[WIDTH-1:0];
          dbz_out_d = dbz_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (o_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dq_q      <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dq_q      <= dq_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign i_ready       = (state_q == S_IDLE);
  assign o_valid       = (state_q == S_DONE);
  assign o_quotient    = quo_out_q;
  assign o_remainder   = rem_out_q;
  assign o_div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_divider_unsigned_iter.sv
// Testbench for divider_unsigned_iter. Three instances (1, 2 and 4 bits per
// cycle) share the stimulus. Results come from plain integer division.
module tb_divider_unsigned_iter;
  localparam int W = 32;
  localparam int N = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready = 1'b1;
  logic [W-1:0]     a_in = '0;
  logic [W-1:0]     b_in = '0;
  logic [N-1:0]     ir, ov, dbz;
  logic [W-1:0]     q [N];
  logic [W-1:0]     r [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    divider_unsigned_iter #(.WIDTH(W), .BITS_PER_CYCLE(1 << g)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (i_valid),
      .i_ready      (ir[g]),
      .i_dividend   (a_in),
      .i_divisor    (b_in),
      .o_valid      (ov[g]),
      .o_ready      (o_ready),
      .o_quotient   (q[g]),
      .o_remainder  (r[g]),
      .o_div_by_zero(dbz[g])
    );
  end

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] cq [N];
  logic [W-1:0] cr [N];
  logic         cdbz [N];
  int           clat [N];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] eq, output logic [W-1:0] er,
                                output logic edbz);
    if (b == 0) begin
      eq = '1; er = a; edbz = 1'b1;
    end else begin
      eq = a / b; er = a % b; edbz = 1'b0;
    end
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 200 && ir != '1; i++) begin
      @(posedge clk); #1;
    end
    check("idle_wait", 64'(ir), 64'(3'b111));
  endtask

  // Issue one operation with o_ready held high and capture each instance's
  // result and latency (edges after the accepting edge).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [N-1:0] seen;
    wait_idle();
    a_in = a; b_in = b; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    seen = '0;
    for (int g = 0; g < N; g++) clat[g] = -1;
    for (int c = 1; c <= 100 && seen != '1; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < N; g++) begin
        if (!seen[g] && ov[g]) begin
          seen[g] = 1'b1;
          clat[g] = c;
          cq[g]   = q[g];
          cr[g]   = r[g];
          cdbz[g] = dbz[g];
        end
      end
    end
  endtask

  task automatic check_caps(input string tag, input logic [W-1:0] eq,
                            input logic [W-1:0] er, input logic edbz);
    for (int g = 0; g < N; g++) begin
      check($sformatf("%s quo bpc%0d", tag, 1 << g), 64'(cq[g]), 64'(eq));
      check($sformatf("%s rem bpc%0d", tag, 1 << g), 64'(cr[g]), 64'(er));
      check($sformatf("%s dbz bpc%0d", tag, 1 << g), 64'(cdbz[g]), 64'(edbz));
      check($sformatf("%s latency bpc%0d", tag, 1 << g), 64'(clat[g]), 64'(W >> g));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b, eq, er;
    logic         edbz;
    int           sel;

    tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1] = '{32'hDEADBEEF,   32'd0,          32'hFFFFFFFF,   32'hDEADBEEF,   1'b1};
    tbl[2] = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    tbl[3] = '{32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
    tbl[4] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
    tbl[5] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};

    // Reset state
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < N; g++) begin
      check($sformatf("reset i_ready bpc%0d", 1 << g), 64'(ir[g]), 64'd1);
      check($sformatf("reset o_valid bpc%0d", 1 << g), 64'(ov[g]), 64'd0);
      check($sformatf("reset quo bpc%0d", 1 << g), 64'(q[g]), 64'd0);
      check($sformatf("reset rem bpc%0d", 1 << g), 64'(r[g]), 64'd0);
      check($sformatf("reset dbz bpc%0d", 1 << g), 64'(dbz[g]), 64'd0);
    end
    #20 rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b);
      check_caps($sformatf("vec%0d", i), tbl[i].q, tbl[i].r, tbl[i].dbz);
    end

    // Result held while o_ready is low; i_valid pulses must be ignored
    wait_idle();
    o_ready = 1'b0;
    a_in = 32'd100; b_in = 32'd7; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int i = 0; i < 100 && ov != '1; i++) begin
      @(posedge clk); #1;
    end
    check("hold reach done", 64'(ov), 64'(3'b111));
    for (int k = 0; k < 10; k++) begin
      i_valid = k[0];
      a_in = $urandom; b_in = $urandom;
      @(posedge clk); #1;
      check("hold o_valid", 64'(ov), 64'(3'b111));
      check("hold i_ready", 64'(ir), 64'(3'b000));
      for (int g = 0; g < N; g++) begin
        check($sformatf("hold quo bpc%0d", 1 << g), 64'(q[g]), 64'd14);
        check($sformatf("hold rem bpc%0d", 1 << g), 64'(r[g]), 64'd2);
        check($sformatf("hold dbz bpc%0d", 1 << g), 64'(dbz[g]), 64'd0);
      end
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(posedge clk); #1;
    check("release o_valid", 64'(ov), 64'(3'b000));
    check("release i_ready", 64'(ir), 64'(3'b111));
    for (int g = 0; g < N; g++)
      check($sformatf("idle keeps quo bpc%0d", 1 << g), 64'(q[g]), 64'd14);
    @(posedge clk); #1;
    check("no stray accept", 64'(ir), 64'(3'b111));

    // Asynchronous reset in the middle of an operation
    wait_idle();
    a_in = 32'hDEADBEEF; b_in = 32'd3; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst i_ready", 64'(ir), 64'(3'b111));
    check("midrst o_valid", 64'(ov), 64'(3'b000));
    for (int g = 0; g < N; g++) begin
      check($sformatf("midrst quo bpc%0d", 1 << g), 64'(q[g]), 64'd0);
      check($sformatf("midrst rem bpc%0d", 1 << g), 64'(r[g]), 64'd0);
      check($sformatf("midrst dbz bpc%0d", 1 << g), 64'(dbz[g]), 64'd0);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op(32'd1000, 32'd10);
    check_caps("after rst 1000/10", 32'd100, 32'd0, 1'b0);

    // Random operands against the integer-division model
    for (int n = 0; n < 1500; n++) begin
      a   = $urandom;
      sel = $urandom_range(0, 6);
      case (sel)
        0:       b = '0;
        1:       b = 32'd1;
        2:       b = '1;
        3:       b = 32'($urandom_range(1, 255));
        4:       b = a;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      model(a, b, eq, er, edbz);
      run_op(a, b);
      check_caps($sformatf("rand%0d %0h/%0h", n, a, b), eq, er, edbz);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
